spi_read_spoofer: RTL and testbench
===================================

// Module: spi_read_spoofer
// PURPOSE
// - Transaction-level MITM controller sitting directly downstream of the SPI bus control block.
// - Drives that block's command interface (cmd_next_chunk / cmd_finish / next_chunk_size).
// - Decodes the first MOSI byte of each SS-framed transaction. On TARGET_CMD it passes address
//   bytes through unchanged, then replaces MISO data bytes with FAKE_BYTE. Otherwise it passes
//   the transaction through untouched.
// PARAMETERS
// - BUF_SIZE         9            bus-control buffer width; must be >= CMD_BITS
// - CHUNK_SIZE_WIDTH clog2(BUF_SIZE+1)  width of next_chunk_size
// - CMD_BITS         8            bits per chunk; every chunk issued is this size
// - TARGET_CMD       8'h03        opcode that triggers spoofing (flash READ)
// - ADDR_CHUNKS      3            pass-through chunks after opcode; 0 allowed
// - MAX_DATA_CHUNKS  4            spoofed data chunks before finish; must be >= 1
// - FAKE_BYTE        8'hA5        value injected on MISO for each data chunk
// PORTS
// - sys_clk          in   1         system clock, all logic on posedge
// - rst              in   1         reset, asynchronous, active-low
// - comm_active      in   1         from bus control: SS-framed transaction in progress
// - bus_ready        in   1         from bus control: idle/chunk complete, data valid
// - real_miso_data   in   BUF_SIZE  captured MISO chunk, valid in [CMD_BITS-1:0]
// - real_mosi_data   in   BUF_SIZE  captured MOSI chunk, valid in [CMD_BITS-1:0]
// - cmd_next_chunk   out  1         one-cycle pulse: process next chunk
// - cmd_finish       out  1         one-cycle pulse: finish transaction
// - next_chunk_size  out  CHUNK_SIZE_WIDTH  constant CMD_BITS while not in reset
// - fake_miso_select out  1         1 = bus control drives MISO from fake buffer
// - fake_mosi_select out  1         tied 0 (MOSI never spoofed)
// - fake_miso_data   out  BUF_SIZE  {zeros, FAKE_BYTE}; 0 in reset
// - fake_mosi_data   out  BUF_SIZE  tied 0
// - match_count      out  8         saturating count of TARGET_CMD hits
// BEHAVIOUR
// - Reset (rst=0, async): every output and counter is 0; state IDLE; phase CMD.
// - States: IDLE, ISSUE, ARM, WAIT, EVAL, FINISH, DRAIN. Phase register: CMD, ADDR, DATA.
// - IDLE: comm_active=1 and bus_ready=1 -> ISSUE, phase=CMD, addr_cnt=0, data_cnt=0.
// - ISSUE: cmd_next_chunk=1 for exactly this cycle. fake_miso_select is registered to
//   (phase==DATA) in the same cycle, so it is stable before the first SCLK fall. -> ARM.
// - ARM: one cycle with bus_ready ignored, because bus control lowers it one cycle after the
//   command. -> WAIT.
// - WAIT: bus_ready=1 -> EVAL. There is no timeout.
// - EVAL, phase CMD: real_mosi_data[CMD_BITS-1:0]==TARGET_CMD -> increment match_count
//   (saturating at 255). Then set phase=ADDR, or phase=DATA if ADDR_CHUNKS==0, and go to
//   ISSUE. On mismatch -> FINISH.
// - EVAL, phase ADDR: addr_cnt++. When addr_cnt reaches ADDR_CHUNKS, set phase=DATA.
//   -> ISSUE.
// - EVAL, phase DATA: data_cnt++. When data_cnt reaches MAX_DATA_CHUNKS -> FINISH,
//   else -> ISSUE.
// - FINISH: cmd_finish=1 for this cycle only; fake_miso_select<=0. -> DRAIN.
// - DRAIN: comm_active=0 -> IDLE. comm_active=1 at DRAIN entry is normal; wait for SS end.
// - Abort: comm_active=0 in ISSUE/ARM/WAIT/EVAL -> IDLE next cycle, fake_miso_select<=0,
//   no cmd_finish. Abort takes priority over the other transitions.
// - cmd_next_chunk and cmd_finish are never high together and never high two cycles in a row.
// - Latency: opcode valid (bus_ready=1 in WAIT) -> next command pulse = 2 cycles (EVAL, ISSUE).
// - Counters are sized clog2 of their limit +1 and cannot wrap. match_count holds at 8'hFF.
// TESTING
// - 1) MOSI opcode 8'h9F -> one cmd_next_chunk, then one cmd_finish; fake_miso_select never 1;
//   match_count=0; after SS fall, state returns to IDLE.
// - 2) Opcode 8'h03, address 8'h12,8'h34,8'h56, slave MISO 8'h00 -> 8 cmd_next_chunk pulses.
//   fake_miso_select=1 from the 5th pulse on; MISO bytes 5..8 at the master = 8'hA5;
//   one cmd_finish; match_count=1.
// - 3) Check each cmd_next_chunk: width = 1 cycle; next pulse only after bus_ready 1->0->1;
//   next_chunk_size=8 at every pulse.
// - 4) rst=0 asserted during the 2nd data chunk WAIT -> all outputs 0 with no clock edge
//   needed. After release with comm_active=0, the block stays IDLE.
// - 5) comm_active forced 0 during ADDR phase -> IDLE next cycle; no cmd_finish; select=0.
// - 6) 260 back-to-back opcode-8'h03 transactions -> match_count=8'hFF; no wrap.

Source files
------------

// File: rtl/spi_read_spoofer_if.sv
// spi_read_spoofer_if: command/data bundle between the SPI bus control block and the read spoofer
// Ports (signals):
//   comm_active      bus control -> spoofer : SS-framed transaction in progress
//   bus_ready        bus control -> spoofer : idle / chunk complete, captured data valid
//   real_miso_data   bus control -> spoofer : captured MISO chunk
//   real_mosi_data   bus control -> spoofer : captured MOSI chunk
//   cmd_next_chunk   spoofer -> bus control : one-cycle pulse, run next chunk
//   cmd_finish       spoofer -> bus control : one-cycle pulse, end transaction
//   next_chunk_size  spoofer -> bus control : bits in the next chunk
//   fake_miso_select spoofer -> bus control : drive MISO from fake_miso_data
//   fake_mosi_select spoofer -> bus control : drive MOSI from fake_mosi_data
//   fake_miso_data   spoofer -> bus control : injected MISO chunk
//   fake_mosi_data   spoofer -> bus control : injected MOSI chunk
//   match_count      spoofer -> observer    : saturating count of target-opcode hits
interface spi_read_spoofer_if #(
    parameter int BUF_SIZE         = 9,
    parameter int CHUNK_SIZE_WIDTH = $clog2(BUF_SIZE + 1)
);
    logic                        comm_active;
    logic                        bus_ready;
    logic [BUF_SIZE-1:0]         real_miso_data;
    logic [BUF_SIZE-1:0]         real_mosi_data;
    logic                        cmd_next_chunk;
    logic                        cmd_finish;
    logic [CHUNK_SIZE_WIDTH-1:0] next_chunk_size;
    logic                        fake_miso_select;
    logic                        fake_mosi_select;
    logic [BUF_SIZE-1:0]         fake_miso_data;
    logic [BUF_SIZE-1:0]         fake_mosi_data;
    logic [7:0]                  match_count;

    modport master (
        input  comm_active, bus_ready, real_miso_data, real_mosi_data,
        output cmd_next_chunk, cmd_finish, next_chunk_size, fake_miso_select,
               fake_mosi_select, fake_miso_data, fake_mosi_data, match_count
    );

    modport slave (
        output comm_active, bus_ready, real_miso_data, real_mosi_data,
        input  cmd_next_chunk, cmd_finish, next_chunk_size, fake_miso_select,
               fake_mosi_select, fake_miso_data, fake_mosi_data, match_count
    );
endinterface

// File: rtl/spi_read_spoofer.sv
// spi_read_spoofer: transaction-level MITM that fakes MISO data bytes of flash READ commands
// Ports:
//   sys_clk  in  system clock, all logic on posedge
//   rst      in  asynchronous active-low reset
//   b        master modport of spi_read_spoofer_if: status/captured data in,
//            chunk commands, fake buffers, selects and match_count out
module spi_read_spoofer #(
    parameter int                  BUF_SIZE         = 9,
    parameter int                  CHUNK_SIZE_WIDTH = $clog2(BUF_SIZE + 1),
    parameter int                  CMD_BITS         = 8,
    parameter logic [CMD_BITS-1:0] TARGET_CMD       = 8'h03,
    parameter int                  ADDR_CHUNKS      = 3,
    parameter int                  MAX_DATA_CHUNKS  = 4,
    parameter logic [CMD_BITS-1:0] FAKE_BYTE        = 8'hA5
) (
    input logic                   sys_clk,
    input logic                   rst,
    spi_read_spoofer_if.master    b
);
    localparam int AW = ADDR_CHUNKS > 0 ? $clog2(ADDR_CHUNKS + 1) : 1;
    localparam int DW = $clog2(MAX_DATA_CHUNKS + 1);
    localparam logic [AW-1:0] ALAST = AW'(ADDR_CHUNKS > 0 ? ADDR_CHUNKS - 1 : 0);
    localparam logic [DW-1:0] DLAST = DW'(MAX_DATA_CHUNKS - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT, EVAL, FINISH, DRAIN} state_t;
    typedef enum logic [1:0] {CMD, ADDR, DATA} phase_t;

    state_t          state, state_nxt;
    phase_t          phase;
    logic [AW-1:0]   addr_cnt;
    logic [DW-1:0]   data_cnt;
    logic [7:0]      match_count;
    logic            sel;
    logic            start, abort, hit;

    assign start = state == IDLE && b.comm_active && b.bus_ready;
    // SS dropping mid-transaction wins over every other transition
    assign abort = !b.comm_active && (state inside {ISSUE, ARM, WAIT, EVAL});
    assign hit   = b.real_mosi_data[CMD_BITS-1:0] == TARGET_CMD;

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort)
            state_nxt = IDLE;
        else
            case (state)
                IDLE:    state_nxt = start ? ISSUE : IDLE;
                ISSUE:   state_nxt = ARM;
                // bus_ready only falls one cycle after the command, so skip it here
                ARM:     state_nxt = WAIT;
                WAIT:    state_nxt = b.bus_ready ? EVAL : WAIT;
                EVAL:    state_nxt = (phase == CMD && !hit) || (phase == DATA && data_cnt == DLAST)
                                     ? FINISH : ISSUE;
                FINISH:  state_nxt = DRAIN;
                DRAIN:   state_nxt = b.comm_active ? DRAIN : IDLE;
                default: state_nxt = IDLE;
            endcase
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            phase       <= CMD;
            addr_cnt    <= '0;
            data_cnt    <= '0;
            match_count <= '0;
            sel         <= 1'b0;
        end else begin
            if (start) begin
                phase    <= CMD;
                addr_cnt <= '0;
                data_cnt <= '0;
            end
            // select settles while the command is issued, ahead of the first SCLK fall
            if (abort || state == FINISH)
                sel <= 1'b0;
            else if (state == ISSUE)
                sel <= phase == DATA;
            if (state == EVAL && !abort)
                case (phase)
                    CMD: if (hit) begin
                        phase <= ADDR_CHUNKS == 0 ? DATA : ADDR;
                        if (match_count != 8'hFF)
                            match_count <= match_count + 8'd1;
                    end
                    ADDR: begin
                        addr_cnt <= addr_cnt + 1'b1;
                        if (addr_cnt == ALAST)
                            phase <= DATA;
                    end
                    default: data_cnt <= data_cnt + 1'b1;
                endcase
        end
    end

    always_comb begin
        b.cmd_next_chunk = state == ISSUE;
        b.cmd_finish     = state == FINISH;
    end

    assign b.next_chunk_size  = rst ? CHUNK_SIZE_WIDTH'(CMD_BITS) : '0;
    assign b.fake_miso_data   = rst ? BUF_SIZE'(FAKE_BYTE) : '0;
    assign b.fake_mosi_data   = '0;
    assign b.fake_mosi_select = 1'b0;
    assign b.fake_miso_select = sel;
    assign b.match_count      = match_count;
endmodule

// File: tb/tb_spi_read_spoofer.sv
// tb_spi_read_spoofer: bus-control model driving spi_read_spoofer, MISO-byte scoreboard
module tb_spi_read_spoofer;
    logic sys_clk = 1'b0;
    logic rst = 1'b0;

    spi_read_spoofer_if #(.BUF_SIZE(9)) bus();
    spi_read_spoofer dut (.sys_clk(sys_clk), .rst(rst), .b(bus));

    always #5 sys_clk = ~sys_clk;

    int n_chk = 0;
    int n_pass = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mosi_q[$];
    logic [7:0] exp_match = 8'h00;

    int nxt_cnt = 0, fin_cnt = 0, sel_cyc = 0, both_err = 0, b2b_err = 0, seq_err = 0;
    logic prev_pulse = 1'b0, need_low = 1'b0;

    always @(negedge sys_clk) begin
        if (bus.cmd_next_chunk) nxt_cnt <= nxt_cnt + 1;
        if (bus.cmd_finish) fin_cnt <= fin_cnt + 1;
        if (bus.fake_miso_select) sel_cyc <= sel_cyc + 1;
        if (bus.cmd_next_chunk && bus.cmd_finish) both_err <= both_err + 1;
        if ((bus.cmd_next_chunk || bus.cmd_finish) && prev_pulse) b2b_err <= b2b_err + 1;
        if (bus.cmd_next_chunk && need_low) seq_err <= seq_err + 1;
        prev_pulse <= bus.cmd_next_chunk || bus.cmd_finish;
        need_low <= bus.cmd_next_chunk ? 1'b1
                  : (!bus.bus_ready || bus.cmd_finish || !bus.comm_active) ? 1'b0 : need_low;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push_read(input logic [7:0] slave_b);
        mosi_q.push_back(8'h03);
        mosi_q.push_back(8'h12);
        mosi_q.push_back(8'h34);
        mosi_q.push_back(8'h56);
        for (int i = 0; i < 4; i++) begin
            mosi_q.push_back(8'h00);
            exp_q.push_back(slave_b);
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(8'hA5);
        exp_match = exp_match == 8'hFF ? 8'hFF : exp_match + 8'd1;
    endtask

    // Serves chunks like the bus control block; returns mid-WAIT of chunk abort_at if nonzero
    task automatic serve(input logic [7:0] slave_b, input int abort_at);
        int lat;
        int chunk;
        bit got;
        logic [7:0] mb, mo;
        chunk = 0;
        lat = 0;
        bus.comm_active = 1'b1;
        bus.bus_ready = 1'b1;
        forever begin
            got = 1'b0;
            for (int i = 1; i <= 12 && !got; i++) begin
                @(negedge sys_clk);
                if (bus.cmd_next_chunk || bus.cmd_finish) begin
                    got = 1'b1;
                    lat = i;
                end
            end
            check("pulse_seen", got, 1);
            if (!got) break;
            if (chunk > 0) check("latency", lat, 2);
            if (bus.cmd_finish) break;
            chunk++;
            check("chunk_size", bus.next_chunk_size, 8);
            @(negedge sys_clk);
            bus.bus_ready = 1'b0;
            repeat (4) @(negedge sys_clk);
            mb = bus.fake_miso_select ? bus.fake_miso_data[7:0] : slave_b;
            if (chunk == abort_at) return;
            repeat (4) @(negedge sys_clk);
            mo = mosi_q.size() > 0 ? mosi_q.pop_front() : 8'h00;
            bus.real_mosi_data = {1'b0, mo};
            bus.real_miso_data = {1'b0, slave_b};
            bus.bus_ready = 1'b1;
            check("sb_depth", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("master_miso", mb, exp_q.pop_front());
        end
        @(negedge sys_clk);
        bus.comm_active = 1'b0;
        repeat (2) @(negedge sys_clk);
    endtask

    initial begin
        int n0, f0, s0;
        bus.comm_active = 1'b0;
        bus.bus_ready = 1'b1;
        bus.real_miso_data = '0;
        bus.real_mosi_data = '0;
        #3;
        check("rst_next", bus.cmd_next_chunk, 0);
        check("rst_finish", bus.cmd_finish, 0);
        check("rst_size", bus.next_chunk_size, 0);
        check("rst_sel", bus.fake_miso_select, 0);
        check("rst_fdata", bus.fake_miso_data, 0);
        check("rst_match", bus.match_count, 0);
        check("rst_mosi_sel", bus.fake_mosi_select, 0);
        check("rst_mosi_data", bus.fake_mosi_data, 0);
        @(negedge sys_clk);
        rst = 1'b1;
        @(negedge sys_clk);
        check("run_size", bus.next_chunk_size, 8);
        check("run_fdata", bus.fake_miso_data, 9'h0A5);

        // non-target opcode passes through
        n0 = nxt_cnt; f0 = fin_cnt; s0 = sel_cyc;
        mosi_q.push_back(8'h9F);
        exp_q.push_back(8'h00);
        serve(8'h00, 0);
        check("t1_next", nxt_cnt - n0, 1);
        check("t1_finish", fin_cnt - f0, 1);
        check("t1_sel", sel_cyc - s0, 0);
        check("t1_match", bus.match_count, exp_match);
        n0 = nxt_cnt;
        repeat (5) @(negedge sys_clk);
        check("t1_idle", nxt_cnt - n0, 0);

        // target READ with spoofed data bytes
        n0 = nxt_cnt; f0 = fin_cnt; s0 = sel_cyc;
        push_read(8'h00);
        serve(8'h00, 0);
        check("t2_next", nxt_cnt - n0, 8);
        check("t2_finish", fin_cnt - f0, 1);
        check("t2_sel_used", sel_cyc - s0 > 0, 1);
        check("t2_sel_off", bus.fake_miso_select, 0);
        check("t2_match", bus.match_count, exp_match);
        check("t2_drained", exp_q.size(), 0);

        // async reset during second data chunk
        push_read(8'h00);
        serve(8'h00, 6);
        exp_q.delete();
        mosi_q.delete();
        check("t4_presel", bus.fake_miso_select, 1);
        #2 rst = 1'b0;
        #1;
        exp_match = 8'h00;
        check("t4_next", bus.cmd_next_chunk, 0);
        check("t4_finish", bus.cmd_finish, 0);
        check("t4_size", bus.next_chunk_size, 0);
        check("t4_sel", bus.fake_miso_select, 0);
        check("t4_fdata", bus.fake_miso_data, 0);
        check("t4_match", bus.match_count, 0);
        bus.comm_active = 1'b0;
        bus.bus_ready = 1'b1;
        @(negedge sys_clk);
        rst = 1'b1;
        n0 = nxt_cnt; f0 = fin_cnt;
        repeat (6) @(negedge sys_clk);
        check("t4_idle_next", nxt_cnt - n0, 0);
        check("t4_idle_fin", fin_cnt - f0, 0);

        // SS drop during address phase
        push_read(8'h00);
        serve(8'h00, 3);
        exp_q.delete();
        mosi_q.delete();
        f0 = fin_cnt;
        bus.comm_active = 1'b0;
        @(negedge sys_clk);
        check("t5_sel", bus.fake_miso_select, 0);
        repeat (4) @(negedge sys_clk);
        bus.bus_ready = 1'b1;
        check("t5_finish", fin_cnt - f0, 0);
        check("t5_match", bus.match_count, exp_match);

        // back-to-back READs saturate match_count
        for (int i = 0; i < 260; i++) begin
            push_read(8'h3C);
            serve(8'h3C, 0);
            if (i == 253) check("t6_match254", bus.match_count, exp_match);
        end
        check("t6_match", bus.match_count, exp_match);
        check("t6_sat", bus.match_count, 8'hFF);
        check("t6_drained", exp_q.size(), 0);

        check("both_high", both_err, 0);
        check("back_to_back", b2b_err, 0);
        check("ready_cycle", seq_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
